// File: rtl/edge_det.sv
// -----------------------------------------------------------------------------
// edge_det
//
// Single-bit synchronous edge detector. The input level is sampled on every
// rising clock edge. When the selected transition is seen, a registered
// one-shot pulse of PULSE_LEN cycles is issued on det_o.
//
// Parameters:
//   EDGE_MODE    0 = rising, 1 = falling, 2 = both edges (3 and above act as 0)
//   PULSE_LEN    pulse length in cycles, 1..255 (0 acts as 1, >255 clamps)
//   SYNC_STAGES  synchronizer depth, 2..4, used only with EDGE_DET_SYNC_EN
//
// Optional feature macro:
//   EDGE_DET_SYNC_EN  when defined, sig_i passes through a SYNC_STAGES-deep
//                     flop chain before edge detection (for asynchronous
//                     sources). When undefined, sig_i must be synchronous
//                     to clk and feeds the detector directly.
//
// Ports:
//   clk    input   single clock, all state updates on its rising edge
//   rst    input   synchronous, active-high reset
//   sig_i  input   level signal to monitor
//   det_o  output  registered detection pulse, active-high
// -----------------------------------------------------------------------------
module edge_det #(
    parameter int EDGE_MODE   = 0,
    parameter int PULSE_LEN   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic det_o
);

    // Out-of-range edge modes fall back to rising-edge detection.
    localparam int EDGE_EFF = (EDGE_MODE == 1) ? 1 :
                              (EDGE_MODE == 2) ? 2 : 0;

    // The counter is 8 bits wide, so the reload value is kept within 1..255.
    localparam int PULSE_EFF = (PULSE_LEN < 1)   ? 1   :
                               (PULSE_LEN > 255) ? 255 : PULSE_LEN;
    localparam logic [7:0] PULSE_CNT = 8'(PULSE_EFF);

    // A synchronizer depth outside 2..4 is a configuration mistake, caught
    // at elaboration regardless of whether the synchronizer is compiled in.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_sync_range
        $error("edge_det: SYNC_STAGES must be in the range 2..4");
    end

    logic       s;
    logic       sig_q;
    logic       hit;
    logic [7:0] cnt;
    logic [7:0] cnt_next;

`ifdef EDGE_DET_SYNC_EN
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 :
                            (SYNC_STAGES > 4) ? 4 : SYNC_STAGES;

    logic [SYNC_N-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], sig_i};
        end
    end

    assign s = sync_q[SYNC_N-1];
`else
    assign s = sig_i;
`endif

    always_comb begin
        hit = 1'b0;
        case (EDGE_EFF)
            1:       hit = ~s & sig_q;
            2:       hit = s ^ sig_q;
            default: hit = s & ~sig_q;
        endcase
    end

    // A hit reloads the counter even mid-pulse, so closely spaced edges
    // merge into one extended pulse instead of producing a second one.
    always_comb begin
        cnt_next = cnt;
        if (hit) begin
            cnt_next = PULSE_CNT;
        end else if (cnt != 8'd0) begin
            cnt_next = cnt - 8'd1;
        end
    end

    // det_o is registered from the next counter value, so it is high exactly
    // while the counter is non-zero, with no path from sig_i to the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
            cnt   <= 8'd0;
            det_o <= 1'b0;
        end else begin
            sig_q <= s;
            cnt   <= cnt_next;
            det_o <= (cnt_next != 8'd0);
        end
    end

endmodule

// File: tb/tb_edge_det.sv
module tb_edge_det;

`ifdef EDGE_DET_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig = 1'b0;

    logic det_r, det_m3, det_p0, det_f, det_b, det_p4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    edge_det #(.EDGE_MODE(0), .PULSE_LEN(1), .SYNC_STAGES(2)) u_r  (.clk(clk), .rst(rst), .sig_i(sig), .det_o(det_r));
    edge_det #(.EDGE_MODE(3), .PULSE_LEN(1), .SYNC_STAGES(2)) u_m3 (.clk(clk), .rst(rst), .sig_i(sig), .det_o(det_m3));
    edge_det #(.EDGE_MODE(0), .PULSE_LEN(0), .SYNC_STAGES(2)) u_p0 (.clk(clk), .rst(rst), .sig_i(sig), .det_o(det_p0));
    edge_det #(.EDGE_MODE(1), .PULSE_LEN(1), .SYNC_STAGES(2)) u_f  (.clk(clk), .rst(rst), .sig_i(sig), .det_o(det_f));
    edge_det #(.EDGE_MODE(2), .PULSE_LEN(1), .SYNC_STAGES(2)) u_b  (.clk(clk), .rst(rst), .sig_i(sig), .det_o(det_b));
    edge_det #(.EDGE_MODE(0), .PULSE_LEN(4), .SYNC_STAGES(2)) u_p4 (.clk(clk), .rst(rst), .sig_i(sig), .det_o(det_p4));

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sig = 1'b0;
        step();
        step();
        checks++;
        if ({det_r, det_m3, det_p0, det_f, det_b, det_p4} !== 6'b0) begin
            $display("FAIL reset_state got=%b exp=000000",
                     {det_r, det_m3, det_p0, det_f, det_b, det_p4});
            errors++;
        end
        rst = 1'b0;
        step();
        step();
        step();
        checks++;
        if ({det_r, det_f, det_b, det_p4} !== 4'b0) begin
            $display("FAIL steady_low got=%b exp=0000", {det_r, det_f, det_b, det_p4});
            errors++;
        end
    endtask

    task automatic test_rising();
        logic e1, e4;
        sig = 1'b1;
        for (int i = 0; i < 7 + LAT; i++) begin
            step();
            e1 = (i == LAT);
            e4 = (i >= LAT) && (i < LAT + 4);
            checks++;
            if (det_r !== e1) begin
                $display("FAIL rise_r cyc=%0d got=%b exp=%b", i, det_r, e1); errors++;
            end
            checks++;
            if (det_m3 !== e1) begin
                $display("FAIL rise_mode3 cyc=%0d got=%b exp=%b", i, det_m3, e1); errors++;
            end
            checks++;
            if (det_p0 !== e1) begin
                $display("FAIL rise_len0 cyc=%0d got=%b exp=%b", i, det_p0, e1); errors++;
            end
            checks++;
            if (det_b !== e1) begin
                $display("FAIL rise_both cyc=%0d got=%b exp=%b", i, det_b, e1); errors++;
            end
            checks++;
            if (det_f !== 1'b0) begin
                $display("FAIL rise_fall_mode cyc=%0d got=%b exp=0", i, det_f); errors++;
            end
            checks++;
            if (det_p4 !== e4) begin
                $display("FAIL rise_len4 cyc=%0d got=%b exp=%b", i, det_p4, e4); errors++;
            end
        end
    endtask

    task automatic test_falling();
        logic e;
        sig = 1'b0;
        for (int i = 0; i < 4 + LAT; i++) begin
            step();
            e = (i == LAT);
            checks++;
            if (det_r !== 1'b0) begin
                $display("FAIL fall_r cyc=%0d got=%b exp=0", i, det_r); errors++;
            end
            checks++;
            if (det_f !== e) begin
                $display("FAIL fall_f cyc=%0d got=%b exp=%b", i, det_f, e); errors++;
            end
            checks++;
            if (det_b !== e) begin
                $display("FAIL fall_b cyc=%0d got=%b exp=%b", i, det_b, e); errors++;
            end
        end
        sig = 1'b1;
        for (int i = 0; i < 4 + LAT; i++) begin
            step();
            e = (i == LAT);
            checks++;
            if (det_r !== e) begin
                $display("FAIL rerise_r cyc=%0d got=%b exp=%b", i, det_r, e); errors++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic e;
        sig = 1'b0;
        for (int i = 0; i < 3 + LAT; i++) step();
        sig = 1'b1;
        for (int i = 0; i <= LAT; i++) step();
        checks++;
        if ({det_r, det_p4} !== 2'b11) begin
            $display("FAIL pre_reset_pulse got=%b exp=11", {det_r, det_p4}); errors++;
        end
        rst = 1'b1;
        step();
        checks++;
        if ({det_r, det_b, det_p4} !== 3'b000) begin
            $display("FAIL reset_mid_pulse got=%b exp=000", {det_r, det_b, det_p4}); errors++;
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 4 + LAT; i++) begin
            step();
            e = (i == LAT);
            checks++;
            if (det_r !== e) begin
                $display("FAIL first_sample_high cyc=%0d got=%b exp=%b", i, det_r, e); errors++;
            end
            checks++;
            if (det_f !== 1'b0) begin
                $display("FAIL first_sample_high_f cyc=%0d got=%b exp=0", i, det_f); errors++;
            end
        end
        rst = 1'b1;
        sig = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4 + LAT; i++) begin
            step();
            checks++;
            if ({det_f, det_r, det_b} !== 3'b000) begin
                $display("FAIL first_sample_low cyc=%0d got=%b exp=000", i, {det_f, det_r, det_b});
                errors++;
            end
        end
    endtask

    task automatic test_both();
        logic eb, er, ef;
        for (int i = 0; i < 8 + LAT; i++) begin
            if (i == 0) sig = 1'b1;
            if (i == 3) sig = 1'b0;
            step();
            eb = (i == LAT) || (i == LAT + 3);
            er = (i == LAT);
            ef = (i == LAT + 3);
            checks++;
            if (det_b !== eb) begin
                $display("FAIL both_b cyc=%0d got=%b exp=%b", i, det_b, eb); errors++;
            end
            checks++;
            if (det_r !== er) begin
                $display("FAIL both_r cyc=%0d got=%b exp=%b", i, det_r, er); errors++;
            end
            checks++;
            if (det_f !== ef) begin
                $display("FAIL both_f cyc=%0d got=%b exp=%b", i, det_f, ef); errors++;
            end
        end
    endtask

    task automatic test_stretch();
        logic e4, er, ef, eb;
        for (int i = 0; i < 10 + LAT; i++) begin
            if (i == 0) sig = 1'b1;
            if (i == 1) sig = 1'b0;
            if (i == 2) sig = 1'b1;
            step();
            e4 = (i >= LAT) && (i <= LAT + 5);
            er = (i == LAT) || (i == LAT + 2);
            ef = (i == LAT + 1);
            eb = (i >= LAT) && (i <= LAT + 2);
            checks++;
            if (det_p4 !== e4) begin
                $display("FAIL stretch_len4 cyc=%0d got=%b exp=%b", i, det_p4, e4); errors++;
            end
            checks++;
            if (det_r !== er) begin
                $display("FAIL stretch_r cyc=%0d got=%b exp=%b", i, det_r, er); errors++;
            end
            checks++;
            if (det_f !== ef) begin
                $display("FAIL stretch_f cyc=%0d got=%b exp=%b", i, det_f, ef); errors++;
            end
            checks++;
            if (det_b !== eb) begin
                $display("FAIL stretch_b cyc=%0d got=%b exp=%b", i, det_b, eb); errors++;
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            sig = ~sig;
            step();
            if (i >= LAT) begin
                checks++;
                if (det_b !== 1'b1) begin
                    $display("FAIL toggle_both cyc=%0d got=%b exp=1", i, det_b); errors++;
                end
            end
        end
    endtask

    task automatic test_glitch();
        sig = 1'b0;
        for (int i = 0; i < 4 + LAT; i++) step();
        for (int i = 0; i < 3 + LAT; i++) begin
            #2 sig = 1'b1;
            #2 sig = 1'b0;
            step();
            checks++;
            if ({det_r, det_f, det_b, det_p4} !== 4'b0000) begin
                $display("FAIL glitch cyc=%0d got=%b exp=0000", i, {det_r, det_f, det_b, det_p4});
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_falling();
        test_reset_mid();
        test_both();
        test_stretch();
        test_back_to_back();
        test_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
